// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a stable lock and
// only then releases the system reset. Runs on the PLL reference clock, so
// it keeps sequencing while the PLL output is dead. Retries on lock
// timeout, counts lock losses in RUN and honours a software relock request.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 7,
  parameter int CNT_W               = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             lock_fail,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [1:0]       state
);

  localparam logic [1:0] ST_PLL_RST   = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_STABLE    = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  // One shared cycle timer; sized for the longest interval it must count.
  localparam int TMR_MAX_A = (RST_PULSE_CYCLES > STABLE_CYCLES) ? RST_PULSE_CYCLES : STABLE_CYCLES;
  localparam int TMR_MAX   = (TMR_MAX_A > LOCK_TIMEOUT_CYCLES) ? TMR_MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int TMR_W     = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] PULSE_LAST   = TMR_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W:0]   RETRY_LIMIT  = (CNT_W+1)'(MAX_RETRIES);

  logic             sync_q1;
  logic             locked_s;
  logic             started;
  logic [TMR_W-1:0] tmr;
  logic [1:0]       state_next;
  logic             timeout;
  logic             lost;
  logic             tmr_clear;
  logic [CNT_W-1:0] retry_sat;

  // Two-flop synchronizer: the only consumer of the asynchronous pll_locked.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q1  <= pll_locked;
      locked_s <= sync_q1;
    end
  end

  // Next-state decode; relock_req overrides every other transition.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    lost       = 1'b0;
    if (relock_req) begin
      state_next = ST_PLL_RST;
    end else begin
      case (state)
        ST_PLL_RST: begin
          if (started && tmr == PULSE_LAST) state_next = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_next = ST_STABLE;
          end else if (tmr == TIMEOUT_LAST) begin
            state_next = ST_PLL_RST;
            timeout    = 1'b1;
          end
        end
        ST_STABLE: begin
          if (!locked_s)                state_next = ST_WAIT_LOCK;
          else if (tmr == STABLE_LAST)  state_next = ST_RUN;
        end
        default: begin // ST_RUN
          if (!locked_s) begin
            state_next = ST_PLL_RST;
            lost       = 1'b1;
          end
        end
      endcase
    end
  end

  // The timer restarts on every state change and on a relock request (fresh
  // pulse even when already in PLL_RST); it is held at 0 until the first edge
  // after reset so that edge begins PLL_RST cycle 0.
  always_comb begin
    tmr_clear = (state_next != state) || relock_req || !started;
    retry_sat = (retry_cnt == '1) ? retry_cnt : retry_cnt + CNT_W'(1);
  end

  // State, timer, registered outputs and the status counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started   <= 1'b0;
      state     <= ST_PLL_RST;
      tmr       <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      lock_fail <= 1'b0;
      loss_cnt  <= '0;
      retry_cnt <= '0;
    end else begin
      started   <= 1'b1;
      state     <= state_next;
      tmr       <= tmr_clear ? '0 : tmr + TMR_W'(1);
      pll_rst   <= (state_next == ST_PLL_RST);
      sys_rst_n <= (state_next == ST_RUN);
      if (timeout) begin
        retry_cnt <= retry_sat;
        if ({1'b0, retry_sat} >= RETRY_LIMIT) lock_fail <= 1'b1;
      end
      if (state_next == ST_RUN && state != ST_RUN) retry_cnt <= '0;
      if (lost && loss_cnt != '1) loss_cnt <= loss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short intervals
// (pulse 4, timeout 20, stable 8, 3 retries): a stimulus table walks clean
// lock, loss, unstable lock, relock and timeout retries; hand-written
// sequences cover loss-counter saturation and asynchronous reset.
module tb_pll_lock_supervisor;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pll_locked;
  logic             relock_req;
  logic             pll_rst;
  logic             sys_rst_n;
  logic             lock_fail;
  logic [CNT_W-1:0] loss_cnt;
  logic [CNT_W-1:0] retry_cnt;
  logic [1:0]       state;

  int tests  = 0;
  int errors = 0;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .STABLE_CYCLES       (8),
    .MAX_RETRIES         (3),
    .CNT_W               (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .lock_fail  (lock_fail),
    .loss_cnt   (loss_cnt),
    .retry_cnt  (retry_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;       // clock edges to advance with these inputs
    logic       locked;
    logic       relock;
    logic [1:0] st;
    logic       prst;
    logic       sysn;
    logic       fail;
    logic [7:0] loss;
    logic [7:0] retry;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance n edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic prst,
                           input logic sysn, input logic fail, input logic [7:0] loss,
                           input logic [7:0] retry);
    check({tag, " state"},     32'(state),     32'(st));
    check({tag, " pll_rst"},   32'(pll_rst),   32'(prst));
    check({tag, " sys_rst_n"}, 32'(sys_rst_n), 32'(sysn));
    check({tag, " lock_fail"}, 32'(lock_fail), 32'(fail));
    check({tag, " loss_cnt"},  32'(loss_cnt),  32'(loss));
    check({tag, " retry_cnt"}, 32'(retry_cnt), 32'(retry));
  endtask

  // Step until state matches, bounded; an expired bound is a failure.
  task automatic wait_state(input string name, input logic [1:0] target, input int budget);
    int k = 0;
    while (state !== target && k < budget) begin
      step(1);
      k++;
    end
    check({name, " reached"}, 32'(state), 32'(target));
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    relock_req = 1'b0;

    // Comments give the edge number (E1 = first edge after reset release).
    //                 n  lk rq st  prst sysn fail loss retry
    vq.push_back('{    4, 0, 0, 0,  1,   0,   0,   0,   0});  // E4 last pulse cycle
    vq.push_back('{    1, 0, 0, 1,  0,   0,   0,   0,   0});  // E5 WAIT_LOCK
    vq.push_back('{   10, 0, 0, 1,  0,   0,   0,   0,   0});  // E15
    vq.push_back('{    2, 1, 0, 1,  0,   0,   0,   0,   0});  // lock raised before E16
    vq.push_back('{    1, 1, 0, 2,  0,   0,   0,   0,   0});  // E18 STABLE
    vq.push_back('{    7, 1, 0, 2,  0,   0,   0,   0,   0});  // E25 still STABLE
    vq.push_back('{    1, 1, 0, 3,  0,   1,   0,   0,   0});  // E26 RUN
    vq.push_back('{    2, 0, 0, 3,  0,   1,   0,   0,   0});  // lock lost before E27
    vq.push_back('{    1, 0, 0, 0,  1,   0,   0,   1,   0});  // E29 loss taken
    vq.push_back('{    3, 1, 0, 0,  1,   0,   0,   1,   0});  // E32 pulse continues
    vq.push_back('{    1, 1, 0, 1,  0,   0,   0,   1,   0});  // E33 WAIT_LOCK
    vq.push_back('{    1, 1, 0, 2,  0,   0,   0,   1,   0});  // E34 STABLE
    vq.push_back('{    5, 1, 0, 2,  0,   0,   0,   1,   0});  // E39 stable count 5
    vq.push_back('{    1, 0, 0, 2,  0,   0,   0,   1,   0});  // one-cycle drop
    vq.push_back('{    1, 1, 0, 2,  0,   0,   0,   1,   0});  // E41
    vq.push_back('{    1, 1, 0, 1,  0,   0,   0,   1,   0});  // E42 back to WAIT_LOCK
    vq.push_back('{    1, 1, 0, 2,  0,   0,   0,   1,   0});  // E43 STABLE again
    vq.push_back('{    7, 1, 0, 2,  0,   0,   0,   1,   0});  // E50 needs 8 fresh
    vq.push_back('{    1, 1, 0, 3,  0,   1,   0,   1,   0});  // E51 RUN
    vq.push_back('{    1, 1, 1, 0,  1,   0,   0,   1,   0});  // relock in RUN
    vq.push_back('{    3, 1, 0, 0,  1,   0,   0,   1,   0});  // full 4-cycle pulse
    vq.push_back('{    1, 1, 0, 1,  0,   0,   0,   1,   0});  // E56 WAIT_LOCK
    vq.push_back('{    1, 1, 1, 0,  1,   0,   0,   1,   0});  // relock in WAIT_LOCK
    vq.push_back('{    3, 1, 0, 0,  1,   0,   0,   1,   0});  // E60
    vq.push_back('{    1, 1, 0, 1,  0,   0,   0,   1,   0});  // E61
    vq.push_back('{    1, 1, 0, 2,  0,   0,   0,   1,   0});  // E62 STABLE
    vq.push_back('{    8, 1, 0, 3,  0,   1,   0,   1,   0});  // E70 RUN
    vq.push_back('{    2, 0, 0, 3,  0,   1,   0,   1,   0});  // drop, locked_s low at E72
    vq.push_back('{    1, 0, 1, 0,  1,   0,   0,   1,   0});  // relock + drop: no loss
    vq.push_back('{    3, 0, 0, 0,  1,   0,   0,   1,   0});  // E76
    vq.push_back('{    1, 0, 0, 1,  0,   0,   0,   1,   0});  // E77 WAIT_LOCK
    vq.push_back('{   19, 0, 0, 1,  0,   0,   0,   1,   0});  // E96 last wait cycle
    vq.push_back('{    1, 0, 0, 0,  1,   0,   0,   1,   1});  // E97 timeout 1
    vq.push_back('{    3, 0, 0, 0,  1,   0,   0,   1,   1});  // E100
    vq.push_back('{    1, 0, 0, 1,  0,   0,   0,   1,   1});  // E101
    vq.push_back('{   19, 0, 0, 1,  0,   0,   0,   1,   1});  // E120
    vq.push_back('{    1, 0, 0, 0,  1,   0,   0,   1,   2});  // E121 timeout 2
    vq.push_back('{    4, 0, 0, 1,  0,   0,   0,   1,   2});  // E125
    vq.push_back('{   19, 0, 0, 1,  0,   0,   0,   1,   2});  // E144
    vq.push_back('{    1, 0, 0, 0,  1,   0,   1,   1,   3});  // E145 timeout 3 -> fail
    vq.push_back('{    4, 1, 0, 1,  0,   0,   1,   1,   3});  // E149 WAIT_LOCK
    vq.push_back('{    1, 1, 0, 2,  0,   0,   1,   1,   3});  // E150 STABLE
    vq.push_back('{    8, 1, 0, 3,  0,   1,   1,   1,   0});  // E158 RUN, fail sticky

    step(2);
    check_all("reset", 2'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      pll_locked = vq[i].locked;
      relock_req = vq[i].relock;
      step(vq[i].n);
      relock_req = 1'b0;
      check_all($sformatf("v%0d", i), vq[i].st, vq[i].prst, vq[i].sysn,
                vq[i].fail, vq[i].loss, vq[i].retry);
    end

    // Loss counter saturation: 300 further losses from loss_cnt = 1.
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      wait_state($sformatf("loss%0d drop", i), 2'd0, 10);
      if (i == 0) check("loss first increment", 32'(loss_cnt), 32'd2);
      pll_locked = 1'b1;
      wait_state($sformatf("loss%0d relock", i), 2'd3, 40);
    end
    check("loss saturated", 32'(loss_cnt), 32'd255);
    check("fail still sticky", 32'(lock_fail), 32'd1);

    // Async reset between edges while in STABLE.
    pll_locked = 1'b0;
    wait_state("pre-reset drop", 2'd0, 10);
    pll_locked = 1'b1;
    wait_state("pre-reset stable", 2'd2, 20);
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async reset", 2'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    step(1);
    rst_n = 1'b1;
    step(4);
    check("post-reset pulse", 32'(pll_rst), 32'd1);
    step(1);
    check("post-reset wait_lock", 32'(state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
